// File: rtl/fir_host_sequencer_if.sv
// Host-side bundle: weight/sample input streams, result stream and the FIR load/compute bus.
interface fir_host_sequencer_if;
  logic        w_valid, w_ready;
  logic [15:0] w_data;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic        r_valid, r_ready;
  logic [15:0] r_data;
  logic [15:0] fir_data;
  logic        fir_wind, fir_load, fir_in_valid;
  logic        fir_out_valid;
  logic [15:0] fir_out;
  logic        err;

  // master: the sequencer; slave: host producers/consumer plus the FIR engine
  modport master (
    input  w_valid, w_data, s_valid, s_data, r_ready, fir_out_valid, fir_out,
    output w_ready, s_ready, r_valid, r_data, fir_data, fir_wind, fir_load, fir_in_valid, err
  );
  modport slave (
    output w_valid, w_data, s_valid, s_data, r_ready, fir_out_valid, fir_out,
    input  w_ready, s_ready, r_valid, r_data, fir_data, fir_wind, fir_load, fir_in_valid, err
  );
endinterface

// File: rtl/fir_host_sequencer.sv
// Serializes weight/sample beats onto the FIR shared load bus, fires a computation once
// weights and a full window are present, and returns one result per new sample.
module fir_host_sequencer #(
  parameter int TAPS        = 16,
  parameter int FIRE_CYCLES = 4,
  parameter int TIMEOUT     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_host_sequencer_if.master bus
);
  localparam int WCW = $clog2(TAPS);
  localparam int SCW = $clog2(TAPS + 1);
  localparam int FCW = $clog2(FIRE_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(TAPS - 1);
  localparam logic [SCW-1:0] S_FULL = SCW'(TAPS);
  localparam logic [FCW-1:0] F_LAST = FCW'(FIRE_CYCLES - 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WSHIFT, SSHIFT, FIRE, WAIT, RESP} state_t;

  state_t         state, state_n;
  logic [WCW-1:0] wcnt, wcnt_n;
  logic [SCW-1:0] scnt, scnt_n;
  logic [FCW-1:0] fcnt, fcnt_n;
  logic [TCW-1:0] timer, timer_n;
  logic           wok, wok_n;
  logic [15:0]    fdata, fdata_n, rdata, rdata_n;
  logic           wind, wind_n, load, load_n, inv, inv_n, rvld, rvld_n, err_q, err_n;

  assign bus.w_ready      = (state == IDLE);
  assign bus.s_ready      = (state == IDLE) & ~bus.w_valid;
  assign bus.fir_data     = fdata;
  assign bus.fir_wind     = wind;
  assign bus.fir_load     = load;
  assign bus.fir_in_valid = inv;
  assign bus.r_valid      = rvld;
  assign bus.r_data       = rdata;
  assign bus.err          = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
      scnt  <= '0;
      fcnt  <= '0;
      timer <= '0;
      wok   <= 1'b0;
      fdata <= '0;
      rdata <= '0;
      wind  <= 1'b0;
      load  <= 1'b0;
      inv   <= 1'b0;
      rvld  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      scnt  <= scnt_n;
      fcnt  <= fcnt_n;
      timer <= timer_n;
      wok   <= wok_n;
      fdata <= fdata_n;
      rdata <= rdata_n;
      wind  <= wind_n;
      load  <= load_n;
      inv   <= inv_n;
      rvld  <= rvld_n;
      err_q <= err_n;
    end
  end

  // Counters advance on acceptance, so in SSHIFT scnt already includes the shifting sample.
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    scnt_n  = scnt;
    fcnt_n  = fcnt;
    timer_n = timer;
    wok_n   = wok;
    fdata_n = fdata;
    rdata_n = rdata;
    wind_n  = 1'b0;
    load_n  = 1'b0;
    inv_n   = 1'b0;
    rvld_n  = rvld;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (bus.w_valid) begin
          state_n = WSHIFT;
          wind_n  = 1'b1;
          fdata_n = bus.w_data;
          wcnt_n  = (wcnt == W_LAST) ? '0 : wcnt + 1'b1;
          if (wcnt == W_LAST) wok_n = 1'b1;
        end else if (bus.s_valid) begin
          state_n = SSHIFT;
          load_n  = 1'b1;
          fdata_n = bus.s_data;
          if (scnt != S_FULL) scnt_n = scnt + 1'b1;
        end
      end
      WSHIFT: state_n = IDLE;
      SSHIFT: begin
        if (wok && scnt == S_FULL) begin
          state_n = FIRE;
          inv_n   = 1'b1;
          fcnt_n  = '0;
        end else begin
          state_n = IDLE;
        end
      end
      FIRE: begin
        if (fcnt == F_LAST) begin
          state_n = WAIT;
          timer_n = '0;
        end else begin
          inv_n  = 1'b1;
          fcnt_n = fcnt + 1'b1;
        end
      end
      WAIT: begin
        // A result arriving on the last allowed cycle beats the timeout.
        if (bus.fir_out_valid) begin
          state_n = RESP;
          rvld_n  = 1'b1;
          rdata_n = bus.fir_out;
          timer_n = '0;
        end else if (timer == T_LAST) begin
          state_n = IDLE;
          err_n   = 1'b1;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      RESP: begin
        if (bus.r_ready) begin
          state_n = IDLE;
          rvld_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fir_host_sequencer.sv
// Directed bench for fir_host_sequencer with a small behavioural FIR engine on the load bus.
module tb_fir_host_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fir_host_sequencer_if bus();

  fir_host_sequencer #(.TAPS(16), .FIRE_CYCLES(4), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int n_wind = 0, n_load = 0, n_inv = 0, n_both = 0;
  int base, k;
  logic [15:0] w_ch[16] = '{default: 16'd0};
  logic [15:0] x_ch[16] = '{default: 16'd0};
  logic mute = 1'b0;
  logic prev_inv = 1'b0;
  int cd = 0;

  function automatic logic [15:0] fir_sum();
    logic [15:0] acc = '0;
    for (int i = 0; i < 16; i++) acc += w_ch[i] * x_ch[i];
    return acc;
  endfunction

  // FIR engine model: newest beat at index 0, answers 3 cycles after in_valid falls.
  always @(posedge clk) begin
    if (bus.fir_wind) begin
      for (int i = 15; i > 0; i--) w_ch[i] <= w_ch[i-1];
      w_ch[0] <= bus.fir_data;
      n_wind  <= n_wind + 1;
    end
    if (bus.fir_load) begin
      for (int i = 15; i > 0; i--) x_ch[i] <= x_ch[i-1];
      x_ch[0] <= bus.fir_data;
      n_load  <= n_load + 1;
    end
    if (bus.fir_in_valid) n_inv <= n_inv + 1;
    if (bus.fir_wind && bus.fir_load) n_both <= n_both + 1;
    prev_inv <= bus.fir_in_valid;
    bus.fir_out_valid <= 1'b0;
    if (prev_inv && !bus.fir_in_valid && !mute) cd <= 3;
    else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        bus.fir_out_valid <= 1'b1;
        bus.fir_out       <= fir_sum();
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_w(input logic [15:0] v);
    bus.w_valid = 1'b1;
    bus.w_data  = v;
    tick();
    bus.w_valid = 1'b0;
    chk("wshift_wind", bus.fir_wind, 1);
    chk("wshift_data", bus.fir_data, v);
    tick();
  endtask

  task automatic send_s(input logic [15:0] v);
    bus.s_valid = 1'b1;
    bus.s_data  = v;
    tick();
    bus.s_valid = 1'b0;
    chk("sshift_load", bus.fir_load, 1);
    chk("sshift_data", bus.fir_data, v);
    tick();
  endtask

  task automatic wait_rv();
    int n = 0;
    while (!bus.r_valid && n < 100) begin
      tick();
      n++;
    end
    chk("r_valid_arrives", bus.r_valid, 1);
  endtask

  task automatic handshake();
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    chk("r_valid_drop", bus.r_valid, 0);
    chk("idle_after_hs", bus.w_ready, 1);
  endtask

  initial begin
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.r_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wind", bus.fir_wind, 0);
    chk("rst_load", bus.fir_load, 0);
    chk("rst_inv", bus.fir_in_valid, 0);
    chk("rst_fdata", bus.fir_data, 0);
    chk("rst_rvalid", bus.r_valid, 0);
    chk("rst_rdata", bus.r_data, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;
    tick();
    chk("idle_w_ready", bus.w_ready, 1);

    // weights 1..16, then 15 samples: no compute yet
    for (int v = 1; v <= 16; v++) send_w(16'(v));
    chk("n_wind_16", n_wind, 16);
    for (int i = 0; i < 15; i++) begin
      send_s(16'd1);
      chk("s_ready_back", bus.s_ready, 1);
    end
    chk("no_fire_15", n_inv, 0);

    send_s(16'd1);
    chk("fire_on_16th", bus.fir_in_valid, 1);
    wait_rv();
    chk("result_136", bus.r_data, 136);
    chk("n_load_16", n_load, 16);
    chk("n_inv_4", n_inv, 4);

    // consumer stalls in RESP
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_rvalid", bus.r_valid, 1);
      chk("hold_rdata", bus.r_data, 136);
      chk("hold_s_ready", bus.s_ready, 0);
      chk("hold_w_ready", bus.w_ready, 0);
    end
    handshake();

    // full window slides: one result per new sample
    send_s(16'd2);
    wait_rv();
    chk("result_152", bus.r_data, 152);
    handshake();

    // FIR never answers
    mute = 1'b1;
    send_s(16'd3);
    k = 0;
    while (bus.fir_in_valid && k < 10) begin
      tick();
      k++;
    end
    chk("fire_ends", bus.fir_in_valid, 0);
    repeat (31) tick();
    chk("err_not_yet", bus.err, 0);
    tick();
    chk("err_timeout", bus.err, 1);
    chk("no_result_on_to", bus.r_valid, 0);
    chk("idle_after_to", bus.w_ready, 1);
    mute = 1'b0;

    send_s(16'd1);
    wait_rv();
    chk("result_180", bus.r_data, 180);
    chk("err_sticky", bus.err, 1);
    handshake();

    // weight and sample offered together
    bus.w_valid = 1'b1;
    bus.w_data  = 16'd2;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'd1;
    #1;
    chk("prio_w_ready", bus.w_ready, 1);
    chk("prio_s_ready", bus.s_ready, 0);
    tick();
    bus.w_valid = 1'b0;
    chk("prio_wind", bus.fir_wind, 1);
    chk("prio_no_load", bus.fir_load, 0);
    chk("prio_wdata", bus.fir_data, 2);
    tick();
    chk("prio_s_next", bus.s_ready, 1);
    tick();
    bus.s_valid = 1'b0;
    chk("prio_load", bus.fir_load, 1);
    chk("prio_sdata", bus.fir_data, 1);
    wait_rv();
    chk("result_181", bus.r_data, 181);
    handshake();

    // reset in the middle of FIRE
    send_s(16'd5);
    chk("fire_before_rst", bus.fir_in_valid, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("arst_inv", bus.fir_in_valid, 0);
    chk("arst_rvalid", bus.r_valid, 0);
    chk("arst_err", bus.err, 0);
    tick();
    rst = 1'b0;
    base = n_inv;
    for (int i = 0; i < 16; i++) send_s(16'd1);
    repeat (40) tick();
    chk("no_fire_wo_weights", n_inv, base);
    chk("no_result_after_rst", bus.r_valid, 0);
    chk("wind_load_exclusive", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
